// File: rtl/mem_writeback_cycle_if.sv
// Data-memory handshake bundle between the memory/write-back stage and the
// data memory. Single outstanding request: req is held until rvalid.
interface mem_writeback_cycle_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_rvalid
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_rvalid
    );
endinterface

// File: rtl/mem_writeback_cycle.sv
// Memory + write-back stage. Runs loads/stores on a single-outstanding
// data-memory handshake, aligns/extends load data and drives the register
// file write port (RegWriteW/RDW/ResultW) one edge after completion.
module mem_writeback_cycle #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  LoadM,
    input  logic                  StoreM,
    input  logic [2:0]            fun3M,
    input  logic [4:0]            RD_M,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [XLEN-1:0]       WriteDataM,
    input  logic [XLEN-1:0]       PCPlus4M,
    output logic                  stall_m,
    mem_writeback_cycle_if.master dmem,
    output logic                  misaligned,
    output logic                  RegWriteW,
    output logic [4:0]            RDW,
    output logic [XLEN-1:0]       ResultW
);

    typedef enum logic [0:0] {S_IDLE, S_ACCESS} state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Fields of the memory instruction, frozen for the whole access
    logic [31:0] r_addr;
    logic [2:0]  r_fun3;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic [1:0]  r_src;
    logic [31:0] r_pc4;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        r_misaligned;
    logic        r_regwrite_w;
    logic [4:0]  r_rd_w;
    logic [31:0] r_result_w;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_drop;
    logic        w_wb_en;
    logic        w_wb_regwrite;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_wdata_b;
    logic [7:0]  w_rd_bytes [4];
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_data;
    logic [1:0]  w_sel_src;
    logic [31:0] w_result;

    assign w_mem_op = valid_m & (LoadM | StoreM);

    // Byte-lane views: read lanes for load extraction, replicated store byte
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_rd_bytes[gi]         = dmem.dmem_rdata[8*gi +: 8];
            assign w_wdata_b[8*gi +: 8]   = WriteDataM[7:0];
        end
    endgenerate

    // Alignment check on the incoming effective address (size from fun3[1:0])
    always_comb begin
        w_misaligned = 1'b0;
        case (fun3M[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = ALUResultM[0];
            default: w_misaligned = |ALUResultM[1:0];
        endcase
    end

    // Store lane replication and byte enables; loads carry no strobes
    always_comb begin
        w_st_wdata = WriteDataM;
        w_st_wstrb = 4'b1111;
        case (fun3M[1:0])
            2'b00: begin
                w_st_wdata = w_wdata_b;
                w_st_wstrb = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{WriteDataM[15:0]}};
                w_st_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
            end
            default: begin
                w_st_wdata = WriteDataM;
                w_st_wstrb = 4'b1111;
            end
        endcase
        if (!StoreM) begin
            w_st_wstrb = 4'b0000;
        end
    end

    // Load extraction from the returned word using the latched offset/size
    always_comb begin
        w_ld_byte   = w_rd_bytes[r_addr[1:0]];
        w_ld_half   = r_addr[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        w_load_data = dmem.dmem_rdata;
        case (r_fun3[1:0])
            2'b00:   w_load_data = {{24{~r_fun3[2] & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_load_data = {{16{~r_fun3[2] & w_ld_half[15]}}, w_ld_half};
            default: w_load_data = dmem.dmem_rdata;
        endcase
    end

    // Write-back mux: live inputs for ALU/link ops, latched copy for memory ops.
    // ResultSrc=01 on a non-memory op has no load data and yields 0.
    always_comb begin
        w_sel_src = (r_state == S_ACCESS) ? r_src : ResultSrcM;
        case (w_sel_src)
            2'b01:   w_result = (r_state == S_ACCESS) ? w_load_data : 32'h0;
            2'b10:   w_result = (r_state == S_ACCESS) ? r_pc4 : PCPlus4M;
            default: w_result = (r_state == S_ACCESS) ? r_addr : ALUResultM;
        endcase
    end

    // Next-state and control: accept/drop memory ops, stall, write-back enables
    always_comb begin
        w_state_next  = r_state;
        stall_m       = 1'b0;
        w_accept      = 1'b0;
        w_drop        = 1'b0;
        w_wb_en       = 1'b0;
        w_wb_regwrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    if (w_misaligned) begin
                        w_drop = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        stall_m      = 1'b1;
                        w_state_next = S_ACCESS;
                    end
                end else if (valid_m) begin
                    w_wb_en       = 1'b1;
                    w_wb_regwrite = RegWriteM & (|RD_M);
                end
            end
            S_ACCESS: begin
                stall_m = ~dmem.dmem_rvalid;
                if (dmem.dmem_rvalid) begin
                    w_wb_en       = 1'b1;
                    w_wb_regwrite = r_regwrite & ~r_we & (|r_rd);
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (rst) begin
            stall_m = 1'b0;
        end
    end

    // State register; reset aborts any pending access
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Latch the memory instruction when it is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_fun3     <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_src      <= '0;
            r_pc4      <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else if (w_accept) begin
            r_addr     <= ALUResultM;
            r_fun3     <= fun3M;
            r_rd       <= RD_M;
            r_regwrite <= RegWriteM;
            r_src      <= ResultSrcM;
            r_pc4      <= PCPlus4M;
            r_we       <= StoreM;
            r_wdata    <= w_st_wdata;
            r_wstrb    <= w_st_wstrb;
        end
    end

    // Write-back registers and misaligned pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_rd_w       <= '0;
            r_result_w   <= '0;
        end else begin
            r_misaligned <= w_drop;
            r_regwrite_w <= w_wb_en & w_wb_regwrite;
            if (w_wb_en) begin
                r_rd_w     <= (r_state == S_ACCESS) ? r_rd : RD_M;
                r_result_w <= w_result;
            end
        end
    end

    assign dmem.dmem_req   = (r_state == S_ACCESS);
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;
    assign misaligned      = r_misaligned;
    assign RegWriteW       = r_regwrite_w;
    assign RDW             = r_rd_w;
    assign ResultW         = r_result_w;

endmodule
